// File: rtl/genius_ctrl_if.sv
// Signal bundle between the Genius game sequencer and its surroundings:
// button/start inputs, the sequence ROM port and the LED/display outputs.
interface genius_ctrl_if;
  logic       start;
  logic [3:0] botoes;
  logic [3:0] seq_addr;
  logic [3:0] seq_data;
  logic [3:0] leds;
  logic [4:0] rodada;
  logic [2:0] estado;
  logic       vitoria;
  logic       derrota;

  modport master (
    input  start, botoes, seq_data,
    output seq_addr, leds, rodada, estado, vitoria, derrota
  );

  modport slave (
    output start, botoes, seq_data,
    input  seq_addr, leds, rodada, estado, vitoria, derrota
  );
endinterface

// File: rtl/genius_ctrl.sv
// Genius (Simon) game sequencer: replays the growing colour sequence from the ROM,
// then checks the player's presses against it, advancing rounds up to MAX_ROUND.
module genius_ctrl #(
  parameter int SHOW_CYCLES    = 50000000,
  parameter int GAP_CYCLES     = 25000000,
  parameter int TIMEOUT_CYCLES = 250000000,
  parameter int MAX_ROUND      = 16
) (
  input  logic          clock,
  input  logic          reset,
  genius_ctrl_if.master bus
);

  localparam int MAX_AB = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int MAX_P  = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int TW     = $clog2(MAX_P) + 1;

  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [4:0]    R_MAX     = 5'(MAX_ROUND);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHOW_ON  = 3'd1,
    SHOW_OFF = 3'd2,
    WAIT_IN  = 3'd3,
    WIN      = 3'd4,
    LOSE     = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [4:0]    rodada_q, rodada_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [4:0] lastIdx;
  logic       pressed;
  logic       pressOk;

  assign lastIdx = rodada_q - 5'd1;
  assign pressed = |bus.botoes;
  assign pressOk = (bus.botoes == bus.seq_data);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rodada_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rodada_q <= rodada_d;
      timer_q  <= timer_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rodada_d = rodada_q;
    timer_d  = timer_q;
    case (state_q)
      IDLE, WIN, LOSE: begin
        if (bus.start) begin
          rodada_d = 5'd1;
          idx_d    = '0;
          timer_d  = '0;
          state_d  = SHOW_ON;
        end
      end
      SHOW_ON: begin
        if (timer_q == SHOW_LAST) begin
          timer_d = '0;
          state_d = SHOW_OFF;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      SHOW_OFF: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          if ({1'b0, idx_q} == lastIdx) begin
            idx_d   = '0;
            state_d = WAIT_IN;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = SHOW_ON;
          end
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      WAIT_IN: begin
        // A press in the timeout cycle still counts, so it is tested first.
        if (pressed) begin
          timer_d = '0;
          if (!pressOk) begin
            state_d = LOSE;
          end else if ({1'b0, idx_q} < lastIdx) begin
            idx_d = idx_q + 4'd1;
          end else if (rodada_q == R_MAX) begin
            state_d = WIN;
          end else begin
            rodada_d = rodada_q + 5'd1;
            idx_d    = '0;
            state_d  = SHOW_ON;
          end
        end else if (timer_q == TO_LAST) begin
          state_d = LOSE;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.leds = 4'b0000;
    case (state_q)
      SHOW_ON: bus.leds = bus.seq_data;
      WIN:     bus.leds = 4'b1111;
      default: bus.leds = 4'b0000;
    endcase
  end

  assign bus.seq_addr = idx_q;
  assign bus.rodada   = rodada_q;
  assign bus.estado   = state_q;
  assign bus.vitoria  = (state_q == WIN);
  assign bus.derrota  = (state_q == LOSE);

endmodule

// File: tb/tb_genius_ctrl.sv
// Randomised scoreboard bench for genius_ctrl: a game-level model queues the expected
// outputs of every cycle and an independent monitor compares them against the DUT.
module tb_genius_ctrl;

  localparam int SHOW = 2;
  localparam int GAP  = 1;
  localparam int TO   = 8;
  localparam int MAXR = 4;

  typedef struct packed {
    logic [3:0] leds;
    logic [2:0] estado;
    logic [4:0] rodada;
    logic [3:0] addr;
    logic       vit;
    logic       der;
  } obs_t;

  typedef struct {
    obs_t  v;
    string tag;
  } exp_t;

  logic clock;
  logic reset;
  logic [3:0] rom [16];

  exp_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;
  obs_t restExp;

  genius_ctrl_if bus ();

  genius_ctrl #(
    .SHOW_CYCLES    (SHOW),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO),
    .MAX_ROUND      (MAXR)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.seq_data = rom[bus.seq_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic obs_t mk(input logic [3:0] l, input int e, input int r, input int a,
                              input logic v, input logic d);
    obs_t o;
    o.leds   = l;
    o.estado = 3'(e);
    o.rodada = 5'(r);
    o.addr   = 4'(a);
    o.vit    = v;
    o.der    = d;
    return o;
  endfunction

  function automatic logic [3:0] noise();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic checkOutput(input exp_t e);
    obs_t a;
    a = {bus.leds, bus.estado, bus.rodada, bus.seq_addr, bus.vitoria, bus.derrota};
    testsRun++;
    if (a !== e.v) begin
      testsFailed++;
      $display("[TB] FAIL %s @%0t: got leds=%b estado=%0d rodada=%0d addr=%0d vit=%b der=%b, want leds=%b estado=%0d rodada=%0d addr=%0d vit=%b der=%b",
               e.tag, $time, a.leds, a.estado, a.rodada, a.addr, a.vit, a.der,
               e.v.leds, e.v.estado, e.v.rodada, e.v.addr, e.v.vit, e.v.der);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // One cycle: queue what the DUT must show in it, then present inputs for the next edge.
  task automatic applyStimulus(input obs_t e, input string tag, input logic [3:0] bot,
                               input logic st, input logic rst);
    exp_t x;
    @(posedge clock);
    #1;
    x.v   = e;
    x.tag = tag;
    expQ.push_back(x);
    bus.botoes = bot;
    bus.start  = st;
    reset      = rst;
  endtask

  task automatic restCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(restExp, "rest", noise(), 1'b0, 1'b0);
  endtask

  task automatic playback(input int r, input int abortAt, output bit aborted);
    int n;
    n = 0;
    aborted = 1'b0;
    for (int i = 0; i < r; i++) begin
      for (int c = 0; c < SHOW; c++) begin
        bit rs;
        rs = (n == abortAt);
        applyStimulus(mk(rom[i], 1, r, i, 1'b0, 1'b0), $sformatf("r%0d show%0d", r, i),
                      noise(), 1'($urandom_range(0, 1)), rs);
        n++;
        if (rs) begin
          aborted = 1'b1;
          return;
        end
      end
      for (int c = 0; c < GAP; c++)
        applyStimulus(mk(4'b0000, 2, r, i, 1'b0, 1'b0), $sformatf("r%0d gap%0d", r, i),
                      noise(), 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  // Returns lost=1 when the round ends in defeat, leaving restExp at the LOSE picture.
  task automatic inputPhase(input int r, input int failIdx, input int failKind,
                            input logic [3:0] wrongVal, input bit forceLate, output bit lost);
    lost = 1'b0;
    for (int i = 0; i < r; i++) begin
      obs_t w;
      int   waits;
      w = mk(4'b0000, 3, r, i, 1'b0, 1'b0);
      if (i == failIdx && failKind == 2) begin
        for (int c = 0; c < TO; c++) applyStimulus(w, $sformatf("r%0d timeout%0d", r, i), 4'b0000, 1'b0, 1'b0);
        restExp = mk(4'b0000, 5, r, i, 1'b0, 1'b1);
        lost = 1'b1;
        return;
      end
      if (forceLate && i == 0) waits = TO - 1;
      else waits = ($urandom_range(0, 3) == 0) ? TO - 1 : $urandom_range(0, TO - 2);
      for (int c = 0; c < waits; c++) applyStimulus(w, $sformatf("r%0d wait%0d", r, i), 4'b0000, 1'b0, 1'b0);
      if (i == failIdx && failKind == 1) begin
        applyStimulus(w, $sformatf("r%0d badpress%0d", r, i), wrongVal, 1'b0, 1'b0);
        restExp = mk(4'b0000, 5, r, i, 1'b0, 1'b1);
        lost = 1'b1;
        return;
      end
      applyStimulus(w, $sformatf("r%0d press%0d", r, i), rom[i], 1'b0, 1'b0);
    end
  endtask

  // failKind: 0 play to victory, 1 wrong press, 2 timeout, 3 reset during playback.
  task automatic playGame(input int failRound, input int failIdx, input int failKind,
                          input logic [3:0] wrongVal, input int abortAt, input bit forceLate);
    bit ab;
    bit lost;
    applyStimulus(restExp, "start", noise(), 1'b1, 1'b0);
    for (int r = 1; r <= MAXR; r++) begin
      playback(r, (failKind == 3 && r == failRound) ? abortAt : -1, ab);
      if (ab) begin
        restExp = mk(4'b0000, 0, 0, 0, 1'b0, 1'b0);
        return;
      end
      inputPhase(r, (r == failRound) ? failIdx : -1, failKind, wrongVal, forceLate, lost);
      if (lost) return;
    end
    restExp = mk(4'b1111, 4, MAXR, MAXR - 1, 1'b1, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rom[0] = 4'b0001;
    rom[1] = 4'b0100;
    rom[2] = 4'b0010;
    rom[3] = 4'b1000;
    for (int i = 4; i < 16; i++) rom[i] = 4'(1 << $urandom_range(0, 3));
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.botoes = 4'b0000;
    restExp    = mk(4'b0000, 0, 0, 0, 1'b0, 1'b0);

    applyStimulus(restExp, "reset", 4'b0000, 1'b0, 1'b1);
    applyStimulus(restExp, "reset", 4'b0000, 1'b0, 1'b0);
    restCycles(3);

    playGame(0, -1, 0, 4'b0000, -1, 1'b1);
    restCycles(3);
    playGame(2, 1, 1, 4'b0010, -1, 1'b0);
    restCycles(2);
    playGame(1, 0, 1, 4'b0011, -1, 1'b0);
    restCycles(2);
    playGame(1, 0, 2, 4'b0000, -1, 1'b0);
    restCycles(2);
    playGame(3, 0, 3, 4'b0000, 2, 1'b0);
    restCycles(2);

    for (int g = 0; g < 12; g++) begin
      int fr, fi, fk, ab;
      logic [3:0] wv;
      fk = $urandom_range(0, 3);
      fr = $urandom_range(1, MAXR);
      fi = $urandom_range(0, fr - 1);
      ab = $urandom_range(0, fr * SHOW - 1);
      do wv = 4'($urandom_range(1, 15)); while (wv == rom[fi]);
      playGame(fr, fi, fk, wv, ab, 1'b0);
      restCycles($urandom_range(1, 3));
    end

    for (int k = 0; k < 4 && expQ.size() > 0; k++) @(negedge clock);
    #1;
    if (expQ.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
